// File: rtl/game_fsm_ctrl.sv
// Pong-style game sequencer: menu, serve countdown, play, optional pause, game over.
// Optional pause feature is enabled by defining GAME_PAUSE_EN.
module game_fsm_ctrl #(
    parameter int WIN_SCORE   = 5,
    parameter int SCORE_W     = 4,
    parameter int SERVE_TICKS = 60
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               timing_tick,
    input  logic               start_btn,
    input  logic               back_btn,
    input  logic               pause_btn,
    input  logic               point_p1,
    input  logic               point_p2,
    output logic [2:0]         state,
    output logic               still_graphic,
    output logic               serve_pulse,
    output logic               serve_dir,
    output logic [SCORE_W-1:0] player1_score,
    output logic [SCORE_W-1:0] player2_score,
    output logic [1:0]         winner
);

    // state     | meaning
    // MENU      | idle, scores from the last game still shown
    // SERVE     | ball frozen, counting timing_tick before launch
    // PLAY      | ball live, point strobes accepted
    // PAUSE     | frozen mid-rally (only with GAME_PAUSE_EN)
    // GAME_OVER | winner latched, waiting for back_btn
    localparam logic [2:0] ST_MENU  = 3'd0;
    localparam logic [2:0] ST_SERVE = 3'd1;
    localparam logic [2:0] ST_PLAY  = 3'd2;
    localparam logic [2:0] ST_PAUSE = 3'd3;
    localparam logic [2:0] ST_OVER  = 3'd4;

    localparam int TICK_W = 10;
    localparam logic [TICK_W-1:0]  TICK_LAST = TICK_W'(SERVE_TICKS - 1);
    localparam logic [SCORE_W-1:0] WIN_VAL   = SCORE_W'(WIN_SCORE);

    logic [2:0]         state_q, state_d;
    logic [SCORE_W-1:0] p1_q, p1_d, p2_q, p2_d;
    logic [1:0]         winner_q, winner_d;
    logic               dir_q, dir_d;
    logic               still_q, still_d;
    logic [TICK_W-1:0]  tick_q, tick_d;
    logic               start_btn_q, back_btn_q;
    logic               start_edge, back_edge;
    logic [SCORE_W-1:0] p1_inc, p2_inc;

    assign start_edge = start_btn & ~start_btn_q;
    assign back_edge  = back_btn & ~back_btn_q;
    assign p1_inc     = p1_q + 1'b1;
    assign p2_inc     = p2_q + 1'b1;

`ifdef GAME_PAUSE_EN
    logic pause_btn_q;
    logic pause_edge;
    assign pause_edge = pause_btn & ~pause_btn_q;

    always_ff @(posedge clk) begin
        if (rst) pause_btn_q <= 1'b1;
        else     pause_btn_q <= pause_btn;
    end
`else
    logic unused_pause;
    assign unused_pause = pause_btn;
`endif

    always_comb begin
        state_d     = state_q;
        p1_d        = p1_q;
        p2_d        = p2_q;
        winner_d    = winner_q;
        dir_d       = dir_q;
        tick_d      = tick_q;
        serve_pulse = 1'b0;

        case (state_q)
            ST_MENU: begin
                if (start_edge) begin
                    state_d  = ST_SERVE;
                    p1_d     = '0;
                    p2_d     = '0;
                    winner_d = 2'b00;
                    dir_d    = 1'b1;
                    tick_d   = '0;
                end
            end
            ST_SERVE: begin
                if (back_edge) begin
                    state_d = ST_MENU;
                    tick_d  = '0;
                end else if (timing_tick) begin
                    if (tick_q == TICK_LAST) begin
                        state_d     = ST_PLAY;
                        tick_d      = '0;
                        serve_pulse = 1'b1;
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
            end
            ST_PLAY: begin
                if (back_edge) begin
                    state_d = ST_MENU;
`ifdef GAME_PAUSE_EN
                end else if (pause_edge) begin
                    state_d = ST_PAUSE;
`endif
                end else if (point_p1 && point_p2) begin
                    state_d = ST_SERVE;
                    tick_d  = '0;
                end else if (point_p1) begin
                    p1_d = p1_inc;
                    if (p1_inc == WIN_VAL) begin
                        state_d  = ST_OVER;
                        winner_d = 2'b01;
                    end else begin
                        state_d = ST_SERVE;
                        dir_d   = 1'b0;
                        tick_d  = '0;
                    end
                end else if (point_p2) begin
                    p2_d = p2_inc;
                    if (p2_inc == WIN_VAL) begin
                        state_d  = ST_OVER;
                        winner_d = 2'b10;
                    end else begin
                        state_d = ST_SERVE;
                        dir_d   = 1'b1;
                        tick_d  = '0;
                    end
                end
            end
            ST_PAUSE: begin
`ifdef GAME_PAUSE_EN
                if (back_edge)       state_d = ST_MENU;
                else if (pause_edge) state_d = ST_PLAY;
`else
                state_d = ST_MENU;
                tick_d  = '0;
`endif
            end
            ST_OVER: begin
                if (back_edge) state_d = ST_MENU;
            end
            default: begin
                state_d = ST_MENU;
                tick_d  = '0;
            end
        endcase

        still_d = (state_d != ST_PLAY);

        // Reset must also suppress the unregistered launch strobe.
        if (rst) serve_pulse = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_MENU;
            p1_q        <= '0;
            p2_q        <= '0;
            winner_q    <= 2'b00;
            dir_q       <= 1'b1;
            still_q     <= 1'b1;
            tick_q      <= '0;
            start_btn_q <= 1'b1;
            back_btn_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            p1_q        <= p1_d;
            p2_q        <= p2_d;
            winner_q    <= winner_d;
            dir_q       <= dir_d;
            still_q     <= still_d;
            tick_q      <= tick_d;
            start_btn_q <= start_btn;
            back_btn_q  <= back_btn;
        end
    end

    assign state         = state_q;
    assign still_graphic = still_q;
    assign serve_dir     = dir_q;
    assign player1_score = p1_q;
    assign player2_score = p2_q;
    assign winner        = winner_q;

endmodule
